// File: rtl/div_pkg.sv
// Shared types and defaults for the iterative restoring divider.
package div_pkg;

    localparam int DIV_WIDTH_DEFAULT = 32;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DONE
    } div_state_t;

endpackage

// File: rtl/cla_sub.sv
// WIDTH-bit subtractor a - b built as a + ~b + 1 over a parallel-prefix carry network.
module cla_sub
    import div_pkg::*;
#(
    parameter int WIDTH = DIV_WIDTH_DEFAULT + 1
) (
    input  logic [WIDTH-1:0] a_i,
    input  logic [WIDTH-1:0] b_i,
    output logic [WIDTH-1:0] diff_o,
    output logic             borrow_o
);

    localparam int unsigned N = WIDTH;

    logic [N-1:0] g;
    logic [N-1:0] p;
    logic [N-1:0] gk;
    logic [N-1:0] pk;

    assign g = a_i & ~b_i;
    assign p = a_i ^ ~b_i;

    // Carry-in of 1 is folded into bit 0, so gk[i] becomes the carry out of bit i.
    always_comb begin
        gk = {g[N-1:1], g[0] | p[0]};
        pk = p;
        for (int unsigned s = 1; s < N; s = s * 2) begin
            gk = gk | (pk & (gk << s));
            pk = pk & (pk << s);
        end
    end

    assign diff_o   = p ^ {gk[N-2:0], 1'b1};
    assign borrow_o = ~gk[N-1];

`ifdef FORMAL
    always_comb begin
        assert (diff_o == a_i - b_i);
        assert (borrow_o == (a_i < b_i));
    end
`endif

endmodule

// File: rtl/div_restoring.sv
// Iterative unsigned restoring divider, one shift-and-subtract step per clock.
// Define DIV_ZERO_FAST_EN to finish a divide-by-zero one cycle after accept.
module div_restoring
    import div_pkg::*;
#(
    parameter int WIDTH = DIV_WIDTH_DEFAULT
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder,
    output logic             div_by_zero
);

    localparam int CW = $clog2(WIDTH);
    localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);

    div_state_t       state_q, state_d;
    logic [WIDTH-1:0] q_q, q_d;
    logic [WIDTH-1:0] d_q, d_d;
    logic [WIDTH:0]   r_q, r_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             dbz_q, dbz_d;
    logic [WIDTH-1:0] quo_q, quo_d;
    logic [WIDTH-1:0] rem_q, rem_d;
    logic             dbz_out_q, dbz_out_d;

    logic [WIDTH:0]   r_shift;
    logic [WIDTH:0]   diff;
    logic             borrow;
    logic             r_msb_unused;

    // The restore keeps R below D, so R's top bit never reaches the next shift.
    assign r_shift      = {r_q[WIDTH-1:0], q_q[WIDTH-1]};
    assign r_msb_unused = r_q[WIDTH];

    cla_sub #(
        .WIDTH(WIDTH + 1)
    ) u_sub (
        .a_i     (r_shift),
        .b_i     ({1'b0, d_q}),
        .diff_o  (diff),
        .borrow_o(borrow)
    );

    always_comb begin
        state_d   = state_q;
        q_d       = q_q;
        d_d       = d_q;
        r_d       = r_q;
        cnt_d     = cnt_q;
        dbz_d     = dbz_q;
        quo_d     = quo_q;
        rem_d     = rem_q;
        dbz_out_d = dbz_out_q;

        case (state_q)
            IDLE: begin
                if (in_valid) begin
                    q_d     = dividend;
                    d_d     = divisor;
                    r_d     = '0;
                    cnt_d   = CNT_LAST;
                    dbz_d   = (divisor == '0);
                    state_d = RUN;
                end
            end
            RUN: begin
`ifdef DIV_ZERO_FAST_EN
                if (dbz_q) begin
                    // Dividend is still unshifted in Q on the first RUN cycle.
                    quo_d     = '1;
                    rem_d     = q_q;
                    dbz_out_d = 1'b1;
                    state_d   = DONE;
                end else begin
`else
                begin
`endif
                    q_d   = {q_q[WIDTH-2:0], ~borrow};
                    r_d   = borrow ? r_shift : diff;
                    cnt_d = cnt_q - 1'b1;
                    if (cnt_q == '0) begin
                        quo_d     = {q_q[WIDTH-2:0], ~borrow};
                        rem_d     = r_d[WIDTH-1:0];
                        dbz_out_d = dbz_q;
                        state_d   = DONE;
                    end
                end
            end
            DONE: begin
                if (out_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            q_q       <= '0;
            d_q       <= '0;
            r_q       <= '0;
            cnt_q     <= '0;
            dbz_q     <= 1'b0;
            quo_q     <= '0;
            rem_q     <= '0;
            dbz_out_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            q_q       <= q_d;
            d_q       <= d_d;
            r_q       <= r_d;
            cnt_q     <= cnt_d;
            dbz_q     <= dbz_d;
            quo_q     <= quo_d;
            rem_q     <= rem_d;
            dbz_out_q <= dbz_out_d;
        end
    end

    assign in_ready    = (state_q == IDLE);
    assign out_valid   = (state_q == DONE);
    assign quotient    = quo_q;
    assign remainder   = rem_q;
    assign div_by_zero = dbz_out_q;

endmodule

// File: tb/tb_div_restoring.sv
// Self-checking bench for div_restoring: cycle-level result model plus directed vectors.
module tb_div_restoring;

    localparam int W = 32;
`ifdef DIV_ZERO_FAST_EN
    localparam bit FAST = 1'b1;
`else
    localparam bit FAST = 1'b0;
`endif
    localparam int ZLAT = FAST ? 1 : W;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         in_valid = 1'b0;
    logic         out_ready = 1'b0;
    logic [W-1:0] dividend = '0;
    logic [W-1:0] divisor = '0;
    logic         in_ready;
    logic         out_valid;
    logic [W-1:0] quotient;
    logic [W-1:0] remainder;
    logic         div_by_zero;

    int n_checks = 0;
    int n_pass = 0;
    bit cmp_en = 1'b0;

    div_restoring #(
        .WIDTH(W)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .dividend   (dividend),
        .divisor    (divisor),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .quotient   (quotient),
        .remainder  (remainder),
        .div_by_zero(div_by_zero)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    endtask

    // Model: result from plain / and %, presented a fixed number of edges after accept.
    logic         m_busy, m_done;
    int unsigned  m_wait;
    logic [W-1:0] p_q, p_r, e_q, e_r;
    logic         p_z, e_z;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_busy <= 1'b0;
            m_done <= 1'b0;
            m_wait <= 0;
            p_q <= '0; p_r <= '0; p_z <= 1'b0;
            e_q <= '0; e_r <= '0; e_z <= 1'b0;
        end else if (m_done) begin
            if (out_ready) m_done <= 1'b0;
        end else if (m_busy) begin
            if (m_wait == 1) begin
                m_busy <= 1'b0;
                m_done <= 1'b1;
                e_q <= p_q; e_r <= p_r; e_z <= p_z;
            end
            m_wait <= m_wait - 1;
        end else if (in_valid) begin
            if (divisor == 0) begin
                p_q <= '1; p_r <= dividend; p_z <= 1'b1;
            end else begin
                p_q <= dividend / divisor; p_r <= dividend % divisor; p_z <= 1'b0;
            end
            m_busy <= 1'b1;
            m_wait <= (FAST && divisor == 0) ? 1 : W;
        end
    end

    always @(negedge clk) begin
        if (cmp_en) begin
            chk("model in_ready", in_ready, !m_busy && !m_done);
            chk("model out_valid", out_valid, m_done);
            chk("model quotient", quotient, e_q);
            chk("model remainder", remainder, e_r);
            chk("model div_by_zero", div_by_zero, e_z);
        end
    end

    task automatic do_op(input logic [W-1:0] a, input logic [W-1:0] b,
                         input logic [W-1:0] eq, input logic [W-1:0] er,
                         input logic ez, input int elat, input int hold);
        int n;
        @(negedge clk);
        dividend = a; divisor = b; in_valid = 1'b1; out_ready = 1'b0;
        n = 0;
        while (!in_ready && n < 100) begin @(negedge clk); n++; end
        chk("accept ready", in_ready, 1);
        @(negedge clk);
        in_valid = 1'b0; dividend = ~a; divisor = b + 1;
        n = 0;
        while (!out_valid && n < 200) begin @(negedge clk); n++; end
        chk("latency", n, elat);
        chk("quotient", quotient, eq);
        chk("remainder", remainder, er);
        chk("div_by_zero", div_by_zero, ez);
        repeat (hold) begin
            in_valid = 1'b1; dividend = 9; divisor = 3;
            @(negedge clk);
            chk("hold in_ready", in_ready, 0);
            chk("hold out_valid", out_valid, 1);
            chk("hold quotient", quotient, eq);
            chk("hold remainder", remainder, er);
        end
        in_valid = 1'b0; out_ready = 1'b1;
        @(negedge clk);
        chk("consumed out_valid", out_valid, 0);
        chk("consumed in_ready", in_ready, 1);
        out_ready = 1'b0;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        logic [W-1:0] ra, rb;
        repeat (2) @(negedge clk);
        chk("reset in_ready", in_ready, 1);
        chk("reset out_valid", out_valid, 0);
        chk("reset quotient", quotient, 0);
        chk("reset remainder", remainder, 0);
        chk("reset div_by_zero", div_by_zero, 0);
        #2 rst_n = 1'b1;
        cmp_en = 1'b1;

        do_op(100, 7, 14, 2, 1'b0, W, 0);
        do_op(32'hFFFF_FFFF, 1, 32'hFFFF_FFFF, 0, 1'b0, W, 0);
        do_op(3, 10, 0, 3, 1'b0, W, 0);
        do_op(5, 0, 32'hFFFF_FFFF, 5, 1'b1, ZLAT, 0);
        do_op(1000, 33, 30, 10, 1'b0, W, 10);
        do_op(7, 7, 1, 0, 1'b0, W, 0);
        do_op(6, 7, 0, 6, 1'b0, W, 0);
        do_op(32'h8000_0000, 32'hFFFF_FFFF, 0, 32'h8000_0000, 1'b0, W, 0);
        do_op(32'hFFFF_FFFF, 32'hFFFF_FFFF, 1, 0, 1'b0, W, 0);
        do_op(0, 5, 0, 0, 1'b0, W, 0);
        for (int i = 0; i < 4; i++) begin
            ra = $urandom;
            rb = $urandom_range(1, 300);
            do_op(ra, rb, ra / rb, ra % rb, 1'b0, W, 0);
        end

        // Back-to-back with out_ready tied high.
        @(negedge clk);
        dividend = 1234; divisor = 10; in_valid = 1'b1; out_ready = 1'b1;
        @(negedge clk);
        dividend = 65535; divisor = 256;
        n = 0;
        while (!out_valid && n < 200) begin @(negedge clk); n++; end
        chk("b2b first latency", n, W);
        chk("b2b first quotient", quotient, 123);
        chk("b2b first remainder", remainder, 4);
        @(negedge clk);
        chk("b2b ready after consume", in_ready, 1);
        @(negedge clk);
        chk("b2b second accepted", in_ready, 0);
        in_valid = 1'b0;
        n = 0;
        while (!out_valid && n < 200) begin @(negedge clk); n++; end
        chk("b2b second latency", n, W);
        chk("b2b second quotient", quotient, 255);
        chk("b2b second remainder", remainder, 255);
        @(negedge clk);
        out_ready = 1'b0;

        // Reset in the middle of RUN.
        @(negedge clk);
        dividend = 200; divisor = 9; in_valid = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        repeat (15) @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        chk("mid-run reset in_ready", in_ready, 1);
        chk("mid-run reset out_valid", out_valid, 0);
        chk("mid-run reset quotient", quotient, 0);
        @(negedge clk);
        #2 rst_n = 1'b1;
        do_op(77, 7, 11, 0, 1'b0, W, 0);

        repeat (3) @(negedge clk);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
